pipeline_sched: RTL
===================

Name: pipeline_sched

Overview:
Central stall/flush scheduler for the 5-stage RV32 pipeline (F/D/E/M/W). It merges hazard requests into one consistent set of per-stage stall and flush enables:
- load-use hazard from decode,
- branch redirect from EX,
- multi-cycle MDU op in EX,
- data-memory wait in MEM.

It tracks multi-cycle waits with a small FSM and a memory-timeout counter. Pipeline registers and PC consume its outputs directly.

Parameters:
MEM_TO_CYCLES, 64, max consecutive MEM_WAIT cycles before timeout abort (>=2)
TO_W, 7, width of timeout counter; must satisfy 2**TO_W > MEM_TO_CYCLES
PERF_W, 32, width of performance counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
ld_hazD  in  1  load-use hazard detected between D and E
br_takenE  in  1  branch/jump in EX resolved taken
mdu_startE  in  1  multi-cycle mul/div op present in EX
mdu_done  in  1  MDU result valid this cycle
dmem_reqM  in  1  load/store in MEM awaiting memory
dmem_ack  in  1  memory completes MEM access this cycle
stallF  out  1  hold PC
stallD  out  1  hold IF/ID register
stallE  out  1  hold ID/EX register
stallM  out  1  hold EX/MEM register
flushD  out  1  bubble into IF/ID
flushE  out  1  bubble into ID/EX
flushM  out  1  bubble into EX/MEM
flushW  out  1  bubble into MEM/WB
pc_redirect  out  1  select branch target for PC
mem_err  out  1  one-cycle pulse on memory timeout
stall_cnt  out  PERF_W  cycles with stallF=1 (feature)
flush_cnt  out  PERF_W  branch-redirect events (feature)

Behaviour:
- Clock is clk. Reset is synchronous, active-low on rst_n: state sampled on rising clk while rst_n=0.
- Reset:
  - FSM->RUN, timeout counter=0, mem_err=0, counters=0.
  - While rst_n=0, outputs combinationally: all stall*=0, all flush*=1, pc_redirect=0.
- FSM states: RUN, MDU_WAIT, MEM_WAIT. Stall/flush outputs are combinational from state and inputs (zero latency); only FSM, counter and mem_err are registered.
- Condition memw = dmem_reqM & ~dmem_ack.
- Condition mduw = (state==MDU_WAIT | mdu_startE) & ~mdu_done.
- Priority 1, memw (or state MEM_WAIT without ack):
  - stallF/D/E/M=1, flushW=1; all others 0.
  - pc_redirect=0, even if br_takenE.
- Priority 2, mduw (no memw):
  - stallF/D/E=1, flushM=1; pc_redirect=0.
- Priority 3, br_takenE (no stall above):
  - pc_redirect=1, flushD=1, flushE=1.
  - ld_hazD is ignored because the wrong-path D instruction is discarded.
- Priority 4, ld_hazD:
  - stallF=1, stallD=1, flushE=1.
- Otherwise all outputs 0.
- A branch held in E during a stall keeps br_takenE high. The redirect fires in the first unstalled cycle.
- Transitions:
  - RUN->MEM_WAIT on memw.
  - RUN->MDU_WAIT on mdu_startE & ~mdu_done & ~memw.
  - MEM_WAIT->RUN on dmem_ack (stalls drop in the ack cycle).
  - MDU_WAIT->RUN on mdu_done (stalls drop in the done cycle).
  - MDU_WAIT->MEM_WAIT on memw. The MDU wait resumes afterwards via mdu_startE still held in E.
- mdu_startE & mdu_done in the same cycle: no stall, stay RUN.
- Timeout counter:
  - Increments each cycle in MEM_WAIT; clears on leaving MEM_WAIT.
  - When it reaches MEM_TO_CYCLES-1 with no ack: mem_err=1 next cycle for exactly 1 cycle.
  - The FSM returns to RUN with stalls released that same cycle. flushW=1 in that cycle so the faulting access never writes back.
  - Counter saturates; it never wraps.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cnt increments every cycle stallF=1.
  - flush_cnt increments on every cycle pc_redirect=1.
  - Both clear on reset and wrap modulo 2**PERF_W.
- Undefined: both ports are driven constant 0 and no counter flops are synthesized.

Test Plan:
- ld_hazD=1 for one cycle, others 0 -> stallF=stallD=flushE=1 that cycle, all 0 next cycle, FSM stays RUN.
- ld_hazD=1 and br_takenE=1 together -> pc_redirect=flushD=flushE=1, stallF=stallD=0.
- mdu_startE=1 held, mdu_done asserted on 5th cycle -> stallF/D/E=flushM=1 for cycles 1-4, 0 on cycle 5; state MDU_WAIT in cycles 2-5, RUN after.
- dmem_reqM=1, dmem_ack on 3rd cycle, br_takenE=1 throughout -> stallF/D/E/M=flushW=1 cycles 1-2, pc_redirect=0 cycles 1-2, pc_redirect=1 cycle 3.
- MEM_TO_CYCLES=4, dmem_reqM=1 held, no ack -> mem_err single-cycle pulse after 4 wait cycles, stalls released, flushW=1 that cycle; rst_n=0 mid-wait -> next cycle FSM RUN, counter 0, flush*=1 during reset.
- With PIPE_PERF_CNT_EN: 3 load-use stalls plus 2 redirects -> stall_cnt=3, flush_cnt=2; without the macro both read 0.

Source files
------------

// File: rtl/pipeline_sched.sv
// Stall/flush scheduler for the 5-stage RV32 pipeline: merges hazard requests into per-stage enables.
// Optional macro PIPE_PERF_CNT_EN adds stall/redirect performance counters.
module pipeline_sched #(
  parameter int MEM_TO_CYCLES = 64,
  parameter int TO_W          = 7,
  parameter int PERF_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_hazD,
  input  logic              br_takenE,
  input  logic              mdu_startE,
  input  logic              mdu_done,
  input  logic              dmem_reqM,
  input  logic              dmem_ack,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              pc_redirect,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MDU_WAIT, MEM_WAIT} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO_CYCLES - 2);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MEM_TO_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_mem_err;
  logic            w_memw;
  logic            w_mem_stall;
  logic            w_mduw;
  logic            w_to_hit;

  // The still-asserted request of an aborted access must not re-arm the wait in the abort cycle.
  always_comb begin
    w_memw      = dmem_reqM & ~dmem_ack & ~r_mem_err;
    w_mem_stall = w_memw | ((r_state == MEM_WAIT) & ~dmem_ack);
    w_mduw      = ((r_state == MDU_WAIT) | mdu_startE) & ~mdu_done;
    w_to_hit    = (r_state == MEM_WAIT) & ~dmem_ack & (r_to_cnt == TO_LAST);
  end

  always_comb begin
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    flushM      = 1'b0;
    flushW      = 1'b0;
    pc_redirect = 1'b0;
    if (!rst_n) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (w_mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else begin
      if (w_mduw) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (br_takenE) begin
        pc_redirect = 1'b1;
        flushD      = 1'b1;
        flushE      = 1'b1;
      end else if (ld_hazD) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      // Aborted access leaves MEM this cycle; keep it from writing back.
      if (r_mem_err) flushW = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (w_memw)                       w_state_next = MEM_WAIT;
        else if (mdu_startE && !mdu_done) w_state_next = MDU_WAIT;
      end
      MDU_WAIT: begin
        if (w_memw)        w_state_next = MEM_WAIT;
        else if (mdu_done) w_state_next = RUN;
      end
      MEM_WAIT: begin
        if (dmem_ack || w_to_hit) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_to_cnt  <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_mem_err <= w_to_hit;
      if (r_state == MEM_WAIT && w_state_next == MEM_WAIT)
        r_to_cnt <= (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;
    end
  end

  assign mem_err = r_mem_err;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF)      r_stall_cnt <= r_stall_cnt + 1'b1;
      if (pc_redirect) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
